iigs_serial_bridge: RTL

IIGS_SERIAL_BRIDGE -- requirements
Module: iigs_serial_bridge

---
 rtl/iigs_serial_pkg.sv | 21 ++
 rtl/serial_fifo.sv | 59 +++++
 rtl/iigs_serial_bridge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iigs_serial_pkg.sv
// Shared state encodings and timing defaults for the IIgs SCC serial bridge.
package iigs_serial_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 1492;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_WAIT_HI = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module serial_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Pointer and occupancy next-state
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != CNTW'(DEPTH)) || do_pop_s);
        wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CNTW'(do_push_s) - CNTW'(do_pop_s);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/iigs_serial_bridge.sv
// 8N1 bridge between the IIgs SCC channel A and a valid/ready host interface:
// SCC TxD is deserialized into an RX FIFO, host bytes are serialized onto SCC RxD.
module iigs_serial_bridge
    import iigs_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk_14m,
    input  logic       reset_n,
    input  logic       scc_txd,
    input  logic       scc_rts,
    output logic       scc_rxd,
    output logic       scc_cts,
    output logic [7:0] h_rx_data,
    output logic       h_rx_valid,
    input  logic       h_rx_ready,
    input  logic [7:0] h_tx_data,
    input  logic       h_tx_valid,
    output logic       h_tx_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    logic            txd_meta_q, txd_sync_q, rts_meta_q, rts_sync_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            frame_err_q, frame_err_d, overrun_q, overrun_d, cts_q, cts_d;
    logic            rx_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [CNTW-1:0] fifo_count_s;
    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            rxd_q, rxd_d, ready_q, ready_d, tx_accept_s;

    // Two-flop synchronizers for the asynchronous SCC inputs
    always_ff @(posedge clk_14m or negedge reset_n) begin
        if (!reset_n) begin
            txd_meta_q <= 1'b1;
            txd_sync_q <= 1'b1;
            rts_meta_q <= 1'b1;
            rts_sync_q <= 1'b1;
        end else begin
            txd_meta_q <= scc_txd;
            txd_sync_q <= txd_meta_q;
            rts_meta_q <= scc_rts;
            rts_sync_q <= rts_meta_q;
        end
    end

    // RX deserializer: samples mid-bit, half a bit after the falling start edge
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_s   = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!txd_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CW'(CLKS_PER_BIT / 2 - 1);
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else if (!txd_sync_q) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else begin
                    rx_shift_d = {txd_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else if (txd_sync_q) begin
                    rx_push_s  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    rx_state_d  = RX_WAIT_HI;
                end
            end
            RX_WAIT_HI: begin
                if (txd_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HI;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
        overrun_d = rx_push_s && fifo_full_s && !fifo_pop_s;
        cts_d     = (fifo_count_s <= CNTW'(FIFO_DEPTH - 2));
    end

    // RX state and registered status outputs
    always_ff @(posedge clk_14m or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            cts_q       <= 1'b1;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            cts_q       <= cts_d;
        end
    end

    assign fifo_pop_s = h_rx_valid && h_rx_ready;

    serial_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk_14m),
        .rst_n     (reset_n),
        .push      (rx_push_s),
        .push_data (rx_shift_q),
        .pop       (fifo_pop_s),
        .head      (h_rx_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // TX serializer; RTS only gates acceptance, never an in-flight frame
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        rxd_d       = rxd_q;
        tx_accept_s = h_tx_valid && ready_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_accept_s) begin
                    tx_state_d = TX_START;
                    tx_shift_d = h_tx_data;
                    tx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                    rxd_d      = 1'b0;
                end else begin
                    rxd_d = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end else begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                    tx_bit_d   = 3'd0;
                    rxd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            TX_DATA: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end else if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                    rxd_d      = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                    rxd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            TX_STOP: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                rxd_d      = 1'b1;
            end
        endcase
        ready_d = (tx_state_d == TX_IDLE) && rts_sync_q && !tx_accept_s;
    end

    // TX state and registered line/handshake outputs
    always_ff @(posedge clk_14m or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            rxd_q      <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rxd_q      <= rxd_d;
            ready_q    <= ready_d;
        end
    end

    assign scc_rxd    = rxd_q;
    assign scc_cts    = cts_q;
    assign h_rx_valid = !fifo_empty_s;
    assign h_tx_ready = ready_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
